// File: rtl/ysyx_23060184_axi_arbiter_pkg.sv
// Shared configuration for the 2-master AXI-lite read/write arbiter:
// bus widths, error response code, FSM encoding and the round-robin pick.
package ysyx_23060184_axi_arbiter_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int WMASK_LENGTH    = 4;
    localparam int ACERR_WIDTH     = 2;
    localparam int NUM_ARB_MASTERS = 2;

    localparam logic [ACERR_WIDTH-1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_M0_RD = 2'd1,
        ST_M1_RD = 2'd2,
        ST_M1_WR = 2'd3
    } arb_state_t;

    // On a tie, the master that did not own the port last time wins.
    function automatic logic rr_pick_m1(input logic req_m0, input logic req_m1,
                                        input logic last_m1);
        return req_m1 & (~req_m0 | ~last_m1);
    endfunction

endpackage

// File: rtl/ysyx_23060184_axi_arbiter.sv
// Arbitrates one AXI-lite slave port between IFU (M0, read only) and MEMU
// (M1, read/write) with a registered round-robin grant and a response watchdog.
module ysyx_23060184_axi_arbiter
    import ysyx_23060184_axi_arbiter_pkg::*;
#(
    parameter int TIMEOUT         = 255,
    parameter int NUM_ARB_MASTERS = ysyx_23060184_axi_arbiter_pkg::NUM_ARB_MASTERS
) (
    input  logic                       clk,
    input  logic                       rstn,

    input  logic [ADDR_WIDTH-1:0]      m0_araddr,
    input  logic                       m0_arvalid,
    output logic                       m0_arready,
    output logic [DATA_WIDTH-1:0]      m0_rdata,
    output logic [ACERR_WIDTH-1:0]     m0_rresp,
    output logic                       m0_rvalid,
    input  logic                       m0_rready,

    input  logic [ADDR_WIDTH-1:0]      m1_araddr,
    input  logic                       m1_arvalid,
    output logic                       m1_arready,
    output logic [DATA_WIDTH-1:0]      m1_rdata,
    output logic [ACERR_WIDTH-1:0]     m1_rresp,
    output logic                       m1_rvalid,
    input  logic                       m1_rready,
    input  logic [ADDR_WIDTH-1:0]      m1_awaddr,
    input  logic                       m1_awvalid,
    output logic                       m1_awready,
    input  logic [DATA_WIDTH-1:0]      m1_wdata,
    input  logic [WMASK_LENGTH-1:0]    m1_wstrb,
    input  logic                       m1_wvalid,
    output logic                       m1_wready,
    output logic [ACERR_WIDTH-1:0]     m1_bresp,
    output logic                       m1_bvalid,
    input  logic                       m1_bready,

    output logic [ADDR_WIDTH-1:0]      s_araddr,
    output logic                       s_arvalid,
    input  logic                       s_arready,
    input  logic [DATA_WIDTH-1:0]      s_rdata,
    input  logic [ACERR_WIDTH-1:0]     s_rresp,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    output logic [ADDR_WIDTH-1:0]      s_awaddr,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [DATA_WIDTH-1:0]      s_wdata,
    output logic [WMASK_LENGTH-1:0]    s_wstrb,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    input  logic [ACERR_WIDTH-1:0]     s_bresp,
    input  logic                       s_bvalid,
    output logic                       s_bready,

    output logic [NUM_ARB_MASTERS-1:0] grant
);

    localparam int                          WDOG_W   = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0]           WDOG_MAX = WDOG_W'(TIMEOUT);
    localparam logic [NUM_ARB_MASTERS-1:0]  GRANT_M0 = NUM_ARB_MASTERS'(1);
    localparam logic [NUM_ARB_MASTERS-1:0]  GRANT_M1 = NUM_ARB_MASTERS'(2);

    arb_state_t                  r_state;
    logic                        r_last_m1;
    logic                        r_ar_done;
    logic                        r_aw_done;
    logic                        r_w_done;
    logic [WDOG_W-1:0]           r_wdog;
    logic [NUM_ARB_MASTERS-1:0]  r_grant;

    logic w_own_m0, w_own_m1r, w_own_m1w, w_own_rd;
    logic w_timeout, w_live;
    logic w_req_m0, w_req_m1r, w_req_m1w, w_req_m1, w_pick_m1;
    logic w_owner_rready, w_rd_end, w_wr_end;

    assign w_own_m0  = (r_state == ST_M0_RD);
    assign w_own_m1r = (r_state == ST_M1_RD);
    assign w_own_m1w = (r_state == ST_M1_WR);
    assign w_own_rd  = w_own_m0 | w_own_m1r;

    assign w_timeout = (r_state != ST_IDLE) && (r_wdog == WDOG_MAX);
    assign w_live    = ~w_timeout;

    assign w_req_m0  = m0_arvalid;
    assign w_req_m1r = m1_arvalid;
    assign w_req_m1w = m1_awvalid & m1_wvalid;
    assign w_req_m1  = w_req_m1r | w_req_m1w;
    assign w_pick_m1 = rr_pick_m1(w_req_m0, w_req_m1, r_last_m1);

    assign grant = r_grant;

    // Slave side: owner's channels pass through, valids gated by done flags and the watchdog.
    assign s_araddr  = w_own_m1r ? m1_araddr : m0_araddr;
    assign s_arvalid = w_live & ~r_ar_done &
                       ((w_own_m0 & m0_arvalid) | (w_own_m1r & m1_arvalid));
    assign w_owner_rready = (w_own_m0 & m0_rready) | (w_own_m1r & m1_rready);
    assign s_rready  = w_live & w_owner_rready;

    assign s_awaddr  = m1_awaddr;
    assign s_wdata   = m1_wdata;
    assign s_wstrb   = m1_wstrb;
    assign s_awvalid = w_live & w_own_m1w & ~r_aw_done & m1_awvalid;
    assign s_wvalid  = w_live & w_own_m1w & ~r_w_done & m1_wvalid;
    assign s_bready  = w_live & w_own_m1w & m1_bready;

    assign m0_arready = w_live & w_own_m0 & ~r_ar_done & s_arready;
    assign m0_rvalid  = w_own_m0 & (w_timeout | s_rvalid);
    assign m0_rdata   = (w_own_m0 & w_live) ? s_rdata : '0;
    assign m0_rresp   = ~w_own_m0 ? '0 : (w_timeout ? DECERR : s_rresp);

    assign m1_arready = w_live & w_own_m1r & ~r_ar_done & s_arready;
    assign m1_rvalid  = w_own_m1r & (w_timeout | s_rvalid);
    assign m1_rdata   = (w_own_m1r & w_live) ? s_rdata : '0;
    assign m1_rresp   = ~w_own_m1r ? '0 : (w_timeout ? DECERR : s_rresp);

    assign m1_awready = w_live & w_own_m1w & ~r_aw_done & s_awready;
    assign m1_wready  = w_live & w_own_m1w & ~r_w_done & s_wready;
    assign m1_bvalid  = w_own_m1w & (w_timeout | s_bvalid);
    assign m1_bresp   = ~w_own_m1w ? '0 : (w_timeout ? DECERR : s_bresp);

    // After a timeout the synthetic error response completes on the master's ready alone.
    assign w_rd_end = w_own_rd & (w_timeout ? w_owner_rready : (s_rvalid & s_rready));
    assign w_wr_end = w_own_m1w & (w_timeout ? m1_bready : (s_bvalid & s_bready));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_last_m1 <= 1'b1;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wdog    <= '0;
            r_grant   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wdog    <= '0;
                    r_ar_done <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (w_req_m0 | w_req_m1) begin
                        if (w_pick_m1) begin
                            r_state <= w_req_m1w ? ST_M1_WR : ST_M1_RD;
                            r_grant <= GRANT_M1;
                        end else begin
                            r_state <= ST_M0_RD;
                            r_grant <= GRANT_M0;
                        end
                    end
                end
                default: begin
                    if (w_rd_end | w_wr_end) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= '0;
                        r_ar_done <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_wdog    <= '0;
                        r_last_m1 <= ~w_own_m0;
                    end else begin
                        if (s_arvalid & s_arready) r_ar_done <= 1'b1;
                        if (s_awvalid & s_awready) r_aw_done <= 1'b1;
                        if (s_wvalid & s_wready)   r_w_done  <= 1'b1;
                        if (r_wdog != WDOG_MAX)    r_wdog    <= r_wdog + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_axi_arbiter.sv
// Directed bench for the AXI arbiter: a table of arbitration vectors, each
// completed as a full transaction, plus hand sequences for blocking, timeout and reset.
module tb_ysyx_23060184_axi_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
    logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
    logic        m1_awvalid, m1_wvalid, m1_bready;
    logic [3:0]  m1_wstrb;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [1:0]  s_rresp, s_bresp;

    logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid;
    logic        m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp, grant;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [3:0]  s_wstrb;

    int checks = 0;
    int errors = 0;
    int aw_hs  = 0;
    int w_hs   = 0;

    ysyx_23060184_axi_arbiter #(.TIMEOUT(8), .NUM_ARB_MASTERS(2)) dut (
        .clk(clk), .rstn(rstn),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_awvalid && s_awready) aw_hs++;
        if (s_wvalid && s_wready)   w_hs++;
    end

    typedef struct packed {
        logic       m0ar;
        logic       m1ar;
        logic       m1aw;
        logic       m1w;
        logic [1:0] exp_grant;
        logic       exp_sar;
        logic       exp_saw;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drop_masters();
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    endtask

    // Address/data handshake, response pass-through, and return to IDLE.
    task automatic finish_txn(input logic [1:0] g, input logic wr, input int idx);
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        #1;
        if (g == 2'b01) begin
            check($sformatf("v%0d_m0_arready", idx), 32'(m0_arready), 32'd1);
            check($sformatf("v%0d_m1_arready_blocked", idx), 32'(m1_arready), 32'd0);
            check($sformatf("v%0d_s_araddr", idx), s_araddr, 32'h1000_0000);
        end else if (wr) begin
            check($sformatf("v%0d_m1_awready", idx), 32'(m1_awready), 32'd1);
            check($sformatf("v%0d_m1_wready", idx), 32'(m1_wready), 32'd1);
            check($sformatf("v%0d_m0_arready_blocked", idx), 32'(m0_arready), 32'd0);
        end else begin
            check($sformatf("v%0d_m1_arready", idx), 32'(m1_arready), 32'd1);
            check($sformatf("v%0d_m0_arready_blocked", idx), 32'(m0_arready), 32'd0);
            check($sformatf("v%0d_s_araddr", idx), s_araddr, 32'h2000_0000);
        end
        tick();
        check($sformatf("v%0d_valids_after_done", idx),
              32'({s_arvalid, s_awvalid, s_wvalid}), 32'd0);
        drop_masters();
        s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        if (wr) begin
            s_bvalid = 1'b1; s_bresp = 2'b01;
            #1;
            check($sformatf("v%0d_m1_bvalid", idx), 32'(m1_bvalid), 32'd1);
            check($sformatf("v%0d_m1_bresp", idx), 32'(m1_bresp), 32'd1);
            check($sformatf("v%0d_rvalids_quiet", idx), 32'({m0_rvalid, m1_rvalid}), 32'd0);
        end else begin
            s_rvalid = 1'b1; s_rdata = 32'hA500_0000 | 32'(idx); s_rresp = 2'b00;
            #1;
            check($sformatf("v%0d_rvalids", idx), 32'({m1_rvalid, m0_rvalid}), 32'(g));
            check($sformatf("v%0d_rdata", idx), (g == 2'b01) ? m0_rdata : m1_rdata,
                  32'hA500_0000 | 32'(idx));
        end
        tick();
        check($sformatf("v%0d_back_to_idle", idx), 32'(grant), 32'd0);
        s_rvalid = 1'b0; s_bvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish, expected finish before 100us");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        m0_araddr = 32'h1000_0000; m1_araddr = 32'h2000_0000;
        m1_awaddr = 32'h4000_0000; m1_wdata = 32'h0; m1_wstrb = 4'hF;
        m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
        s_rdata = 32'h0; s_rresp = 2'b00; s_bresp = 2'b00;

        // Reset with everything asserted: all handshake outputs must stay low.
        rstn = 1'b0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; s_rvalid = 1'b1; s_bvalid = 1'b1;
        #22;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_master_side", 32'({m0_arready, m0_rvalid, m1_arready, m1_rvalid,
                                      m1_awready, m1_wready, m1_bvalid}), 32'd0);
        check("rst_slave_side", 32'({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 32'd0);
        drop_masters();
        s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_rvalid = 1'b0; s_bvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            m0_arvalid = vecs[i].m0ar; m1_arvalid = vecs[i].m1ar;
            m1_awvalid = vecs[i].m1aw; m1_wvalid  = vecs[i].m1w;
            tick();
            $display("vec %0d: req m0ar=%b m1ar=%b m1aw=%b m1w=%b -> grant=%b",
                     i, vecs[i].m0ar, vecs[i].m1ar, vecs[i].m1aw, vecs[i].m1w, grant);
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("v%0d_s_arvalid", i), 32'(s_arvalid), 32'(vecs[i].exp_sar));
            check($sformatf("v%0d_s_awvalid", i), 32'(s_awvalid), 32'(vecs[i].exp_saw));
            if (vecs[i].exp_grant != 2'b00) finish_txn(vecs[i].exp_grant, vecs[i].exp_saw, i);
            else drop_masters();
        end

        // M0 holds the port; an M1 write must wait for M0's read response.
        m0_araddr = 32'h3000_0000; m0_arvalid = 1'b1;
        tick();
        check("blk_grant_m0", 32'(grant), 32'd1);
        s_arready = 1'b1;
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0;
        m1_awaddr = 32'h8000_0010; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
        m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
        s_awready = 1'b1; s_wready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("blk_m1_wait%0d", k),
                  32'({m1_awready, m1_wready, s_awvalid, s_wvalid}), 32'd0);
            tick();
        end
        s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
        #1;
        check("blk_m0_rdata", m0_rdata, 32'h0BAD_F00D);
        tick();
        s_rvalid = 1'b0;
        check("blk_idle_gap", 32'(grant), 32'd0);
        $display("txn m0 read 0x30000000 done, m1 write pending");
        begin
            int aw_base, w_base;
            aw_base = aw_hs; w_base = w_hs;
            tick();
            check("wr_grant_m1", 32'(grant), 32'd2);
            check("wr_s_awaddr", s_awaddr, 32'h8000_0010);
            check("wr_s_wstrb", 32'(s_wstrb), 32'h3);
            check("wr_s_wdata", s_wdata, 32'h1234_5678);
            tick();
            tick();
            drop_masters();
            s_awready = 1'b0; s_wready = 1'b0;
            s_bvalid = 1'b1; s_bresp = 2'b00;
            #1;
            check("wr_m1_bvalid", 32'(m1_bvalid), 32'd1);
            tick();
            s_bvalid = 1'b0;
            check("wr_back_to_idle", 32'(grant), 32'd0);
            check("wr_aw_handshakes", 32'(aw_hs - aw_base), 32'd1);
            check("wr_w_handshakes", 32'(w_hs - w_base), 32'd1);
            $display("txn m1 write 0x80000010 wstrb=0011 done");
        end

        // Slave never answers: watchdog reply after 8 granted cycles.
        m0_araddr = 32'h1000_0000; m0_rready = 1'b0; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
        m0_arvalid = 1'b1;
        tick();
        check("to_grant_m0", 32'(grant), 32'd1);
        s_arready = 1'b1;
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            tick();
            check($sformatf("to_quiet_c%0d", k), 32'(m0_rvalid), 32'd0);
        end
        tick();
        check("to_rvalid", 32'(m0_rvalid), 32'd1);
        check("to_rresp", 32'(m0_rresp), 32'd3);
        check("to_rdata", m0_rdata, 32'd0);
        tick();
        tick();
        check("to_hold", 32'({m0_rvalid, m0_rresp}), 32'h7);
        m0_rready = 1'b1;
        #1;
        check("to_s_rready_dropped", 32'(s_rready), 32'd0);
        tick();
        check("to_back_to_idle", 32'(grant), 32'd0);
        $display("txn m0 read timeout done");

        // Reset in the middle of an M1 write after its address handshake.
        m1_awaddr = 32'h8000_0020; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
        s_awready = 1'b1; s_wready = 1'b0;
        tick();
        check("rw_grant_m1", 32'(grant), 32'd2);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("rw_grant_cleared", 32'(grant), 32'd0);
        check("rw_outputs_low", 32'({m1_awready, m1_wready, m1_bvalid, s_awvalid,
                                     s_wvalid, s_bready}), 32'd0);
        drop_masters();
        s_awready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        tick();
        check("rw_fresh_tie_m0", 32'(grant), 32'd1);
        finish_txn(2'b01, 1'b0, 99);
        $display("txn reset mid-write then fresh tie done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
